// File: rtl/dmvm_mh.sv
// dmvm_mh: multi-head attention-coefficient unit. Per head it computes
// e_h = act(a_src_h . WH_src + a_nbr_h . WH_node), with a pipelined adder tree and valid/ready flow control.
module dmvm_mh #(
    parameter int DATA_WIDTH      = 8,
    parameter int WH_DATA_WIDTH   = 12,
    parameter int DMVM_DATA_WIDTH = 19,
    parameter int NUM_FEATURE_OUT = 16,
    parameter int NUM_HEADS       = 2,
    parameter int MAX_NODES       = 168,
    parameter int LEAKY_SHIFT     = 3,
    parameter int NUM_STAGES      = $clog2(NUM_FEATURE_OUT) + 1
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       act_mode_i,
    input  logic                                                       a_vld_i,
    output logic                                                       a_rdy_o,
    input  logic [NUM_HEADS-1:0][2*NUM_FEATURE_OUT-1:0][DATA_WIDTH-1:0] a_i,
    input  logic                                                       wh_vld_i,
    output logic                                                       wh_rdy_o,
    input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH+$clog2(MAX_NODES):0]   wh_data_i,
    output logic                                                       coef_vld_o,
    input  logic                                                       coef_rdy_i,
    output logic [NUM_HEADS-1:0][DATA_WIDTH-1:0]                       coef_o,
    output logic                                                       coef_last_o
);
    localparam int F              = NUM_FEATURE_OUT;
    localparam int LOG2F          = NUM_STAGES - 1;
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int WORD_W         = F * WH_DATA_WIDTH + NUM_NODE_WIDTH + 1;
    localparam int PW             = DATA_WIDTH + WH_DATA_WIDTH;
    localparam int SHIFT          = DMVM_DATA_WIDTH - DATA_WIDTH;

    typedef logic signed [DMVM_DATA_WIDTH-1:0] acc_t;
    typedef logic signed [DMVM_DATA_WIDTH:0]   sum_t;

    localparam sum_t SAT_MAX = sum_t'((1 << (DATA_WIDTH - 1)) - 1);
    localparam sum_t SAT_MIN = sum_t'(-(1 << (DATA_WIDTH - 1)));

    logic [NUM_HEADS-1:0][2*F-1:0][DATA_WIDTH-1:0] a_q;
    logic signed [WH_DATA_WIDTH-1:0]               wh [F];
    logic signed [PW-1:0]                          prod [NUM_HEADS][2*F];
    // Heap-ordered tree: leaves 2F..4F-1 hold products, node 2 is the src sum, node 3 the nbr sum.
    acc_t                                          node_q [NUM_HEADS][2:4*F-1];
    logic [LOG2F:0]                                vld_q;
    logic [LOG2F:0]                                src_q;
    logic [NUM_NODE_WIDTH-1:0]                     nn_q [LOG2F+1];
    acc_t                                          srcreg_q [NUM_HEADS];
    logic [NUM_NODE_WIDTH-1:0]                     rem_q;
    logic [NUM_NODE_WIDTH-1:0]                     rem_d;
    logic                                          last_d;
    sum_t                                          sum_c [NUM_HEADS];
    sum_t                                          act_c [NUM_HEADS];
    sum_t                                          scl_c [NUM_HEADS];
    sum_t                                          sat_c [NUM_HEADS];
    logic [NUM_HEADS-1:0][DATA_WIDTH-1:0]          coef_d;
    logic                                          en;

    assign en       = !coef_vld_o || coef_rdy_i;
    assign wh_rdy_o = en;
    assign a_rdy_o  = !(|vld_q) && !coef_vld_o;

    always_comb begin
        for (int j = 0; j < F; j++)
            wh[j] = $signed(wh_data_i[WORD_W-1-j*WH_DATA_WIDTH -: WH_DATA_WIDTH]);
        for (int h = 0; h < NUM_HEADS; h++)
            for (int j = 0; j < 2 * F; j++)
                prod[h][j] = $signed(a_q[h][j]) * wh[j % F];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            a_q <= '0;
        else if (a_vld_i && a_rdy_o)
            a_q <= a_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_q <= '0;
        else if (en)
            vld_q <= {vld_q[LOG2F-1:0], wh_vld_i};
    end

    // NOTE: the tree and its side-band are qualified by vld_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            src_q <= {src_q[LOG2F-1:0], wh_data_i[0]};
            nn_q[0] <= wh_data_i[NUM_NODE_WIDTH:1];
            for (int s = 1; s <= LOG2F; s++)
                nn_q[s] <= nn_q[s-1];
            for (int h = 0; h < NUM_HEADS; h++) begin
                for (int j = 0; j < 2 * F; j++)
                    node_q[h][2*F+j] <= acc_t'(prod[h][j]);
                for (int i = 2; i < 2 * F; i++)
                    node_q[h][i] <= node_q[h][2*i] + node_q[h][2*i+1];
            end
        end
    end

    always_comb begin
        // NOTE: defaults first on every comb output so no path infers a latch.
        rem_d  = rem_q;
        coef_d = '0;
        for (int h = 0; h < NUM_HEADS; h++) begin
            sum_c[h] = sum_t'(src_q[LOG2F] ? node_q[h][2] : srcreg_q[h]) + sum_t'(node_q[h][3]);
            if (!sum_c[h][DMVM_DATA_WIDTH])
                act_c[h] = sum_c[h];
            else if (act_mode_i)
                act_c[h] = sum_c[h] >>> LEAKY_SHIFT;
            else
                act_c[h] = '0;
            scl_c[h] = act_c[h] >>> SHIFT;
            if (scl_c[h] > SAT_MAX)
                sat_c[h] = SAT_MAX;
            else if (scl_c[h] < SAT_MIN)
                sat_c[h] = SAT_MIN;
            else
                sat_c[h] = scl_c[h];
            coef_d[h] = sat_c[h][DATA_WIDTH-1:0];
        end
        // A neighbour past the end of its subgraph saturates the count at zero.
        if (src_q[LOG2F])
            rem_d = nn_q[LOG2F] - 1'b1;
        else if (rem_q != '0)
            rem_d = rem_q - 1'b1;
        last_d = (rem_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_vld_o  <= 1'b0;
            coef_o      <= '0;
            coef_last_o <= 1'b0;
            rem_q       <= '0;
            for (int h = 0; h < NUM_HEADS; h++)
                srcreg_q[h] <= '0;
        end else if (en) begin
            coef_vld_o <= vld_q[LOG2F];
            if (vld_q[LOG2F]) begin
                coef_o      <= coef_d;
                coef_last_o <= last_d;
                rem_q       <= rem_d;
                if (src_q[LOG2F])
                    for (int h = 0; h < NUM_HEADS; h++)
                        srcreg_q[h] <= node_q[h][2];
            end
        end
    end
endmodule

// File: tb/tb_dmvm_mh.sv
// Self-checking bench for dmvm_mh: a word-level reference model plus directed scenarios with literal expectations.
module tb_dmvm_mh;
    localparam int H      = 2;
    localparam int F      = 16;
    localparam int DW     = 8;
    localparam int WHW    = 12;
    localparam int NNW    = 8;
    localparam int WORD_W = F * WHW + NNW + 1;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          act_mode_i = 1'b0;
    logic                          a_vld_i = 1'b0;
    logic                          a_rdy_o;
    logic [H-1:0][2*F-1:0][DW-1:0] a_i = '0;
    logic                          wh_vld_i = 1'b0;
    logic                          wh_rdy_o;
    logic [WORD_W-1:0]             wh_data_i = '0;
    logic                          coef_vld_o;
    logic                          coef_rdy_i = 1'b1;
    logic [H-1:0][DW-1:0]          coef_o;
    logic                          coef_last_o;

    dmvm_mh dut (
        .clk(clk), .rst(rst), .act_mode_i(act_mode_i),
        .a_vld_i(a_vld_i), .a_rdy_o(a_rdy_o), .a_i(a_i),
        .wh_vld_i(wh_vld_i), .wh_rdy_o(wh_rdy_o), .wh_data_i(wh_data_i),
        .coef_vld_o(coef_vld_o), .coef_rdy_i(coef_rdy_i),
        .coef_o(coef_o), .coef_last_o(coef_last_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Back-pressure pattern 1,0,0,1 repeating while enabled.
    bit         bp_on = 1'b0;
    int         bp_k = 0;
    logic [3:0] bp_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        if (bp_on) begin
            coef_rdy_i = bp_pat[bp_k % 4];
            bp_k++;
        end else begin
            coef_rdy_i = 1'b1;
        end
    end

    typedef struct packed { int c0; int c1; bit last; } exp_t;
    exp_t   q[$];
    exp_t   log_q[$];
    int     ma [H][2*F];
    longint msrc [H];
    int     mrem = 0;

    function automatic longint wrap19(input longint x);
        longint m;
        m = x & ((longint'(1) << 19) - 1);
        if (m >= (longint'(1) << 18)) m -= (longint'(1) << 19);
        return m;
    endfunction

    function automatic int act_scale(input longint sum, input bit leaky);
        longint v;
        v = sum;
        if (v < 0) v = leaky ? (v >>> 3) : 0;
        v = v >>> 11;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic model_reset();
        q.delete();
        mrem = 0;
        for (int h = 0; h < H; h++) begin
            msrc[h] = 0;
            for (int j = 0; j < 2 * F; j++) ma[h][j] = 0;
        end
    endtask

    task automatic model_word();
        int     whv [F];
        int     c [H];
        longint s, n;
        bit     src;
        int     nn;
        exp_t   e;
        src = wh_data_i[0];
        nn  = int'(wh_data_i[NNW:1]);
        for (int j = 0; j < F; j++) whv[j] = int'($signed(wh_data_i[WORD_W-1-j*WHW -: WHW]));
        for (int h = 0; h < H; h++) begin
            s = 0;
            n = 0;
            for (int j = 0; j < F; j++) begin
                s += ma[h][j] * whv[j];
                n += ma[h][F+j] * whv[j];
            end
            if (src) msrc[h] = wrap19(s);
            c[h] = act_scale(msrc[h] + wrap19(n), act_mode_i);
        end
        if (src) mrem = nn - 1;
        else if (mrem > 0) mrem--;
        e.c0 = c[0];
        e.c1 = c[1];
        e.last = (mrem == 0);
        q.push_back(e);
    endtask

    // Single compare process: model update and output check once per cycle, away from the active edge.
    bit   stall_prev = 1'b0;
    exp_t prev;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            model_reset();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_vld", coef_vld_o, 1);
                check("stall_coef0", $signed(coef_o[0]), prev.c0);
                check("stall_coef1", $signed(coef_o[1]), prev.c1);
                check("stall_last", coef_last_o, prev.last);
            end
            check("wh_rdy_en", wh_rdy_o, !coef_vld_o || coef_rdy_i);
            if (coef_vld_o && coef_rdy_i) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("coef0", $signed(coef_o[0]), e.c0);
                    check("coef1", $signed(coef_o[1]), e.c1);
                    check("last", coef_last_o, e.last);
                end
                log_q.push_back('{c0: int'($signed(coef_o[0])), c1: int'($signed(coef_o[1])),
                                  last: coef_last_o});
            end
            if (wh_vld_i && wh_rdy_o) model_word();
            if (a_vld_i && a_rdy_o)
                for (int h = 0; h < H; h++)
                    for (int j = 0; j < 2 * F; j++) ma[h][j] = int'($signed(a_i[h][j]));
            stall_prev = coef_vld_o && !coef_rdy_i;
            prev.c0 = int'($signed(coef_o[0]));
            prev.c1 = int'($signed(coef_o[1]));
            prev.last = coef_last_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int h, input int sb, input int ss, input int nb, input int ns);
        for (int j = 0; j < F; j++) begin
            a_i[h][j]   = DW'(sb + ss * j);
            a_i[h][F+j] = DW'(nb + ns * j);
        end
    endtask

    task automatic load_w();
        a_vld_i = 1'b1;
        tick();
        a_vld_i = 1'b0;
    endtask

    task automatic send(input int base, input int step, input int nn, input bit src);
        bit acc;
        acc = 1'b0;
        for (int j = 0; j < F; j++) wh_data_i[WORD_W-1-j*WHW -: WHW] = WHW'(base + step * j);
        wh_data_i[NNW:1] = NNW'(nn);
        wh_data_i[0] = src;
        wh_vld_i = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = wh_rdy_o;
            tick();
        end
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        wh_vld_i = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = (q.size() == 0) && !coef_vld_o;
        end
        check("drain", done, 1);
        tick();
    endtask

    initial begin
        int t0;
        bit seen;
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        check("rst_vld", coef_vld_o, 0);
        check("rst_coef", coef_o, 0);
        check("rst_last", coef_last_o, 0);
        check("rst_wh_rdy", wh_rdy_o, 1);
        check("rst_a_rdy", a_rdy_o, 1);
        tick();
        rst = 1'b0;

        // Basic: head 0 weights 64, head 1 zero; three-node subgraph.
        set_w(0, 64, 0, 64, 0);
        set_w(1, 0, 0, 0, 0);
        load_w();
        log_q.delete();
        send(64, 0, 3, 1);
        t0 = cyc - 1;
        send(64, 0, 0, 0);
        send(64, 0, 0, 0);
        wh_vld_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = coef_vld_o;
        end
        check("latency", cyc - t0, 6);
        tick();
        drain();
        check("basic_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("basic0_c0", log_q[0].c0, 64);
            check("basic0_c1", log_q[0].c1, 0);
            check("basic0_last", log_q[0].last, 0);
            check("basic1_last", log_q[1].last, 0);
            check("basic2_c0", log_q[2].c0, 64);
            check("basic2_last", log_q[2].last, 1);
        end

        // Saturation, single-node subgraph, then a neighbour past its end.
        log_q.delete();
        send(200, 0, 1, 1);
        send(64, 0, 0, 0);
        drain();
        check("sat_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("sat_c0", log_q[0].c0, 127);
            check("sat_last", log_q[0].last, 1);
            check("over_c0", log_q[1].c0, 127);
            check("over_last", log_q[1].last, 1);
        end

        // Negative sum: ReLU then LeakyReLU.
        set_w(0, 0, 0, -64, 0);
        load_w();
        log_q.delete();
        send(64, 0, 1, 1);
        drain();
        act_mode_i = 1'b1;
        tick();
        send(64, 0, 1, 1);
        drain();
        check("neg_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("neg_relu", log_q[0].c0, 0);
            check("neg_leaky", log_q[1].c0, -4);
        end

        // Varied vectors on both heads in LeakyReLU mode.
        set_w(0, -20, 3, 15, -2);
        set_w(1, 5, 1, -7, 1);
        load_w();
        send(-50, 7, 3, 1);
        send(30, -4, 0, 0);
        send(100, -13, 0, 0);
        drain();
        act_mode_i = 1'b0;
        tick();

        // Back-pressure: ten back-to-back words under the 1,0,0,1 ready pattern.
        log_q.delete();
        bp_on = 1'b1;
        send(-60, -3, 10, 1);
        for (int k = 1; k < 10; k++) send(k * 17 - 60, k - 3, 0, 0);
        drain();
        bp_on = 1'b0;
        tick();
        check("bp_n", log_q.size(), 10);
        if (log_q.size() == 10) begin
            check("bp_last8", log_q[8].last, 0);
            check("bp_last9", log_q[9].last, 1);
        end

        // Weight load while busy is ignored; a load while idle applies.
        set_w(0, 64, 0, 64, 0);
        set_w(1, 0, 0, 0, 0);
        load_w();
        log_q.delete();
        send(64, 0, 2, 1);
        wh_vld_i = 1'b0;
        set_w(0, 32, 0, 32, 0);
        a_vld_i = 1'b1;
        @(negedge clk);
        check("a_rdy_busy", a_rdy_o, 0);
        tick();
        a_vld_i = 1'b0;
        send(64, 0, 0, 0);
        drain();
        check("a_rdy_idle", a_rdy_o, 1);
        load_w();
        send(64, 0, 1, 1);
        drain();
        check("wl_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("wl_old0", log_q[0].c0, 64);
            check("wl_old1", log_q[1].c0, 64);
            check("wl_new", log_q[2].c0, 32);
        end

        // Reset with four words in flight.
        set_w(0, 64, 0, 64, 0);
        load_w();
        log_q.delete();
        for (int k = 0; k < 4; k++) send(64, 0, 5, k == 0);
        wh_vld_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_vld", coef_vld_o, 0);
        check("post_rst_coef", coef_o, 0);
        check("post_rst_a_rdy", a_rdy_o, 1);
        tick();
        repeat (10) tick();
        check("post_rst_silent", log_q.size(), 0);
        load_w();
        send(64, 0, 0, 0);
        drain();
        check("rst_nbr_n", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("rst_nbr_c0", log_q[0].c0, 32);
            check("rst_nbr_last", log_q[0].last, 1);
        end

        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
